// File: rtl/udp_rx_chan_packer_if.sv
// -----------------------------------------------------------------------------
// udp_rx_chan_packer_if
// Groups the UDP receive-side stream signals of udp_rx_chan_packer into one
// bundle:
//   s_hdr_*      UDP header handshake and fields, from the UDP core
//   s_payload_*  byte-wide payload stream, from the UDP core
//   m_*          packed output word stream, to the per-channel consumer / FIFO
// Modports:
//   slave  - the packer's view: it consumes the s_* side and drives m_*
//   master - the environment's view: it drives s_* and m_ready
// -----------------------------------------------------------------------------
interface udp_rx_chan_packer_if #(
    parameter int DATA_W = 64,
    parameter int CH_W   = 2
);
    localparam int KEEP_W = DATA_W / 8;

    // Header channel
    logic              s_hdr_valid;
    logic              s_hdr_ready;
    logic [31:0]       s_ip_source_ip;
    logic [31:0]       s_ip_dest_ip;
    logic [15:0]       s_source_port;
    logic [15:0]       s_dest_port;

    // Payload byte stream
    logic [7:0]        s_payload_tdata;
    logic              s_payload_tvalid;
    logic              s_payload_tready;
    logic              s_payload_tlast;
    logic              s_payload_tuser;

    // Packed output word stream
    logic [DATA_W-1:0] m_data;
    logic [KEEP_W-1:0] m_keep;
    logic [CH_W-1:0]   m_chan;
    logic              m_valid;
    logic              m_last;
    logic              m_user;
    logic              m_ready;

    modport slave (
        input  s_hdr_valid, s_ip_source_ip, s_ip_dest_ip, s_source_port, s_dest_port,
        input  s_payload_tdata, s_payload_tvalid, s_payload_tlast, s_payload_tuser,
        input  m_ready,
        output s_hdr_ready, s_payload_tready,
        output m_data, m_keep, m_chan, m_valid, m_last, m_user
    );

    modport master (
        output s_hdr_valid, s_ip_source_ip, s_ip_dest_ip, s_source_port, s_dest_port,
        output s_payload_tdata, s_payload_tvalid, s_payload_tlast, s_payload_tuser,
        output m_ready,
        input  s_hdr_ready, s_payload_tready,
        input  m_data, m_keep, m_chan, m_valid, m_last, m_user
    );
endinterface

// File: rtl/udp_rx_chan_packer.sv
// -----------------------------------------------------------------------------
// udp_rx_chan_packer
// Multi-channel UDP receive filter and payload packer (core clock domain).
// Each incoming datagram header is matched against the local IP, optionally
// the expected source IP/port, and up to CH_N enabled local ports. Matching
// payload is packed little-endian into DATA_W words with a byte keep mask and
// tagged with the winning (lowest) channel index; non-matching datagrams are
// drained without output. Accepted/dropped datagrams are counted.
//
// Ports:
//   clk, rst_n    core clock, asynchronous active-low reset
//   bus           udp_rx_chan_packer_if.slave: header, payload and output word
//   local_ip      required destination IP of the datagram
//   dest_ip       required source IP (only when MATCH_SRC=1)
//   dest_port     required source port (only when MATCH_SRC=1)
//   ch_port       channel k local port at [16k+:16]
//   ch_en         per-channel enable
//   pkt_cnt       accepted datagrams (wrapping)
//   drop_cnt      dropped datagrams (wrapping)
// -----------------------------------------------------------------------------
module udp_rx_chan_packer #(
    parameter int DATA_W    = 64,
    parameter int CH_N      = 4,
    parameter int MATCH_SRC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    udp_rx_chan_packer_if.slave  bus,
    input  logic [31:0]          local_ip,
    input  logic [31:0]          dest_ip,
    input  logic [15:0]          dest_port,
    input  logic [16*CH_N-1:0]   ch_port,
    input  logic [CH_N-1:0]      ch_en,
    output logic [31:0]          pkt_cnt,
    output logic [31:0]          drop_cnt
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int CH_W   = (CH_N > 1) ? $clog2(CH_N) : 1;
    localparam int IDX_W  = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    // Registered state
    state_t              state_q;
    logic [DATA_W-1:0]   buf_q;      // partially collected word, unused lanes 0
    logic [IDX_W-1:0]    idx_q;      // lane of the next payload byte
    logic [CH_W-1:0]     chan_q;     // channel latched at header handshake
    logic [DATA_W-1:0]   m_data_q;
    logic [KEEP_W-1:0]   m_keep_q;
    logic [CH_W-1:0]     m_chan_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic                m_user_q;
    logic [31:0]         pkt_cnt_q;
    logic [31:0]         drop_cnt_q;

    // Combinational helpers
    logic                ip_ok_s;
    logic                src_ok_s;
    logic                port_hit_s;
    logic [CH_W-1:0]     hit_chan_s;
    logic                match_s;
    logic                hdr_ready_s;
    logic                tready_s;
    logic                hdr_hs_s;
    logic                byte_hs_s;
    logic                word_done_s;
    logic [DATA_W-1:0]   word_s;
    logic [KEEP_W-1:0]   keep_s;

    // Channel search: scan from the top so the lowest matching channel wins.
    always_comb begin
        port_hit_s = 1'b0;
        hit_chan_s = '0;
        for (int k = CH_N - 1; k >= 0; k--) begin
            if (ch_en[k] && (bus.s_dest_port == ch_port[16*k +: 16])) begin
                port_hit_s = 1'b1;
                hit_chan_s = CH_W'(k);
            end else begin
                port_hit_s = port_hit_s;
                hit_chan_s = hit_chan_s;
            end
        end
    end

    // Datagram acceptance decision for the header currently offered.
    always_comb begin
        ip_ok_s = (bus.s_ip_dest_ip == local_ip);
        if (MATCH_SRC == 0) begin
            src_ok_s = 1'b1;
        end else begin
            src_ok_s = (bus.s_ip_source_ip == dest_ip) && (bus.s_source_port == dest_port);
        end
        match_s = ip_ok_s && src_ok_s && port_hit_s;
    end

    // Handshake readiness: payload is only back-pressured while accepting and
    // the output register holds a word the consumer has not taken.
    always_comb begin
        hdr_ready_s = (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE:   tready_s = 1'b1;
            ST_DROP:   tready_s = 1'b1;
            ST_ACCEPT: tready_s = !m_valid_q || bus.m_ready;
            default:   tready_s = 1'b1;
        endcase
        hdr_hs_s  = bus.s_hdr_valid && hdr_ready_s;
        byte_hs_s = bus.s_payload_tvalid && tready_s;
    end

    // Lane insertion of the incoming byte and keep mask up to the current lane.
    always_comb begin
        word_s      = buf_q | (DATA_W'(bus.s_payload_tdata) << {idx_q, 3'b000});
        word_done_s = (idx_q == IDX_W'(KEEP_W - 1)) || bus.s_payload_tlast;
        keep_s      = '0;
        for (int l = 0; l < KEEP_W; l++) begin
            if (l <= int'(idx_q)) begin
                keep_s[l] = 1'b1;
            end else begin
                keep_s[l] = 1'b0;
            end
        end
    end

    // Filter/packer FSM together with output register and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            chan_q     <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_chan_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_user_q   <= 1'b0;
            pkt_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            // Consumer takes the word; a word loaded below overrides this.
            if (m_valid_q && bus.m_ready) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    // Stray payload bytes are accepted and discarded here.
                    if (hdr_hs_s) begin
                        chan_q <= hit_chan_s;
                        idx_q  <= '0;
                        buf_q  <= '0;
                        if (match_s) begin
                            state_q   <= ST_ACCEPT;
                            pkt_cnt_q <= pkt_cnt_q + 32'd1;
                        end else begin
                            state_q    <= ST_DROP;
                            drop_cnt_q <= drop_cnt_q + 32'd1;
                        end
                    end
                end

                ST_ACCEPT: begin
                    if (byte_hs_s) begin
                        if (word_done_s) begin
                            // byte_hs_s implies the output register is free
                            // or being emptied this cycle.
                            m_data_q  <= word_s;
                            m_keep_q  <= keep_s;
                            m_chan_q  <= chan_q;
                            m_valid_q <= 1'b1;
                            m_last_q  <= bus.s_payload_tlast;
                            m_user_q  <= bus.s_payload_tlast & bus.s_payload_tuser;
                            buf_q     <= '0;
                            idx_q     <= '0;
                        end else begin
                            buf_q <= word_s;
                            idx_q <= idx_q + IDX_W'(1);
                        end
                        if (bus.s_payload_tlast) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                ST_DROP: begin
                    if (byte_hs_s && bus.s_payload_tlast) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_hdr_ready      = hdr_ready_s;
    assign bus.s_payload_tready = tready_s;
    assign bus.m_data           = m_data_q;
    assign bus.m_keep           = m_keep_q;
    assign bus.m_chan           = m_chan_q;
    assign bus.m_valid          = m_valid_q;
    assign bus.m_last           = m_last_q;
    assign bus.m_user           = m_user_q;
    assign pkt_cnt              = pkt_cnt_q;
    assign drop_cnt             = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_chan_packer.sv
// -----------------------------------------------------------------------------
// tb_udp_rx_chan_packer
// Two packer instances (MATCH_SRC=1 and MATCH_SRC=0) share one stimulus source;
// use0 selects which one receives header/payload valids. Expected words are
// produced by a byte-list reference model and queued; a monitor pops and
// compares whenever the selected instance presents a word that is accepted.
// -----------------------------------------------------------------------------
module tb_udp_rx_chan_packer;
    localparam int DATA_W = 64;
    localparam int CH_N   = 4;
    localparam int KEEP_W = DATA_W / 8;
    localparam int CH_W   = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [CH_W-1:0]   chan;
        logic              last;
        logic              user;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                hdr_valid;
    logic [31:0]         sip, dip;
    logic [15:0]         sport, dport;
    logic [7:0]          tdata;
    logic                tvalid, tlast, tuser;
    logic                m_ready;
    logic                use0;
    logic [31:0]         local_ip, dest_ip;
    logic [15:0]         dest_port;
    logic [16*CH_N-1:0]  ch_port;
    logic [CH_N-1:0]     ch_en;
    logic [31:0]         pkt1, drop1, pkt0, drop0;

    udp_rx_chan_packer_if #(.DATA_W(DATA_W), .CH_W(CH_W)) if1 ();
    udp_rx_chan_packer_if #(.DATA_W(DATA_W), .CH_W(CH_W)) if0 ();

    assign if1.s_hdr_valid      = hdr_valid && !use0;
    assign if0.s_hdr_valid      = hdr_valid && use0;
    assign if1.s_payload_tvalid = tvalid && !use0;
    assign if0.s_payload_tvalid = tvalid && use0;
    assign if1.s_ip_source_ip   = sip;    assign if0.s_ip_source_ip  = sip;
    assign if1.s_ip_dest_ip     = dip;    assign if0.s_ip_dest_ip    = dip;
    assign if1.s_source_port    = sport;  assign if0.s_source_port   = sport;
    assign if1.s_dest_port      = dport;  assign if0.s_dest_port     = dport;
    assign if1.s_payload_tdata  = tdata;  assign if0.s_payload_tdata = tdata;
    assign if1.s_payload_tlast  = tlast;  assign if0.s_payload_tlast = tlast;
    assign if1.s_payload_tuser  = tuser;  assign if0.s_payload_tuser = tuser;
    assign if1.m_ready          = m_ready; assign if0.m_ready        = m_ready;

    udp_rx_chan_packer #(.DATA_W(DATA_W), .CH_N(CH_N), .MATCH_SRC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .local_ip(local_ip), .dest_ip(dest_ip),
        .dest_port(dest_port), .ch_port(ch_port), .ch_en(ch_en),
        .pkt_cnt(pkt1), .drop_cnt(drop1)
    );
    udp_rx_chan_packer #(.DATA_W(DATA_W), .CH_N(CH_N), .MATCH_SRC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .local_ip(local_ip), .dest_ip(dest_ip),
        .dest_port(dest_port), .ch_port(ch_port), .ch_en(ch_en),
        .pkt_cnt(pkt0), .drop_cnt(drop0)
    );

    // Outputs of the currently selected instance
    logic              hdr_rdy, tready, mv, mlast, muser;
    logic [DATA_W-1:0] mdata;
    logic [KEEP_W-1:0] mkeep;
    logic [CH_W-1:0]   mchan;
    assign hdr_rdy = use0 ? if0.s_hdr_ready      : if1.s_hdr_ready;
    assign tready  = use0 ? if0.s_payload_tready : if1.s_payload_tready;
    assign mv      = use0 ? if0.m_valid : if1.m_valid;
    assign mdata   = use0 ? if0.m_data  : if1.m_data;
    assign mkeep   = use0 ? if0.m_keep  : if1.m_keep;
    assign mchan   = use0 ? if0.m_chan  : if1.m_chan;
    assign mlast   = use0 ? if0.m_last  : if1.m_last;
    assign muser   = use0 ? if0.m_user  : if1.m_user;

    int              n_chk = 0;
    int              n_fail = 0;
    exp_t            exp_q[$];
    logic [7:0]      cur_bytes[$];
    bit              cur_acc;
    logic [CH_W-1:0] cur_chan;
    int unsigned     mdl_pkt[2];
    int unsigned     mdl_drop[2];
    bit              rdy_rand = 1'b0;
    bit              scramble = 1'b0;
    bit              lat_due  = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference decision: plain reading of the filter rules.
    function automatic void model_hdr(input bit msrc, output bit acc, output logic [CH_W-1:0] ch);
        bit found = 1'b0;
        ch = '0;
        for (int k = 0; k < CH_N; k++) begin
            if (!found && ch_en[k] && ch_port[16*k +: 16] == dport) begin
                found = 1'b1;
                ch = CH_W'(k);
            end
        end
        acc = (dip == local_ip) && (!msrc || (sip == dest_ip && sport == dest_port)) && found;
    endfunction

    function automatic void randomize_cfg();
        ch_en = CH_N'($urandom);
        for (int k = 0; k < CH_N; k++) ch_port[16*k +: 16] = 16'h0100 + 16'($urandom_range(0, 5));
        local_ip  = ($urandom % 2 == 0) ? 32'hC0A8_0001 : 32'hC0A8_0002;
        dest_ip   = ($urandom % 2 == 0) ? 32'h0A00_0002 : 32'h0A00_0003;
        dest_port = ($urandom % 2 == 0) ? 16'h1234 : 16'h4321;
    endfunction

    task automatic do_hdr(input logic [31:0] s_ip, d_ip, input logic [15:0] sp, dp);
        sip = s_ip; dip = d_ip; sport = sp; dport = dp; hdr_valid = 1'b1;
        model_hdr(!use0, cur_acc, cur_chan);
        @(negedge clk);
        chk("hdr_ready_idle", hdr_rdy, 1);
        @(posedge clk); #1;
        hdr_valid = 1'b0;
        sip = $urandom; dip = $urandom; sport = 16'($urandom); dport = 16'($urandom);
        if (cur_acc) mdl_pkt[use0]++; else mdl_drop[use0]++;
        cur_bytes.delete();
        if (scramble) randomize_cfg();
        @(negedge clk);
        chk("pkt_cnt", use0 ? pkt0 : pkt1, mdl_pkt[use0]);
        chk("drop_cnt", use0 ? drop0 : drop1, mdl_drop[use0]);
        @(posedge clk); #1;
    endtask

    // mode 0: accepted datagram, 1: dropped datagram, 2: stray byte in IDLE
    task automatic do_byte(input logic [7:0] d, input logic last, input logic usr, input int mode);
        bit   hs = 1'b0;
        exp_t e;
        tdata = d; tlast = last; tuser = usr; tvalid = 1'b1;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk);
            chk("payload_tready", tready, (mode == 0) ? (!mv || m_ready) : 1'b1);
            chk("hdr_ready_state", hdr_rdy, (mode == 2) ? 1'b1 : 1'b0);
            hs = tready;
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        if (!hs) begin
            n_chk++; n_fail++;
            $display("FAIL byte_timeout: byte 0x%0h not accepted, required acceptance", d);
        end else if (mode == 0) begin
            cur_bytes.push_back(d);
            if (cur_bytes.size() == KEEP_W || last) begin
                e = '0;
                for (int i = 0; i < cur_bytes.size(); i++) begin
                    e.data[8*i +: 8] = cur_bytes[i];
                    e.keep[i] = 1'b1;
                end
                e.chan = cur_chan;
                e.last = last;
                e.user = last & usr;
                exp_q.push_back(e);
                cur_bytes.delete();
                lat_due = 1'b1;
            end
        end
    endtask

    task automatic send_dgram(input logic [31:0] s_ip, d_ip, input logic [15:0] sp, dp,
                              input int n, input bit usr, input bit pattern);
        do_hdr(s_ip, d_ip, sp, dp);
        for (int i = 0; i < n; i++) begin
            do_byte(pattern ? 8'(i) : 8'($urandom), (i == n - 1),
                    (i == n - 1) ? usr : 1'($urandom), cur_acc ? 0 : 1);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !mv;
        end
        chk("drain_done", done, 1);
        @(posedge clk); #1;
    endtask

    // Random output back-pressure
    initial begin : ready_gen
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        exp_t got, held, e;
        bit   hold_pending = 1'b0;
        forever begin
            @(negedge clk);
            got = {mdata, mkeep, mchan, mlast, muser};
            if (!rst_n) begin
                hold_pending = 1'b0;
            end else begin
                chk("idle_dut_quiet", use0 ? if1.m_valid : if0.m_valid, 0);
                if (lat_due) begin
                    chk("latency_m_valid", mv, 1);
                    lat_due = 1'b0;
                end
                if (hold_pending) begin
                    chk("stall_valid_held", mv, 1);
                    chk("stall_word_held", got, held);
                end
                if (mv && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h, required no word", mdata, mkeep);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", got.data, e.data);
                        chk("word_keep", got.keep, e.keep);
                        chk("word_chan", got.chan, e.chan);
                        chk("word_last", got.last, e.last);
                        chk("word_user", got.user, e.user);
                    end
                end
                hold_pending = mv && !m_ready;
                held = got;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : stim
        logic [31:0] r_sip, r_dip;
        logic [15:0] r_sp, r_dp;
        hdr_valid = 1'b0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = 8'h00;
        sip = 32'd0; dip = 32'd0; sport = 16'd0; dport = 16'd0;
        m_ready = 1'b1; use0 = 1'b0;
        local_ip = 32'hC0A8_0001; dest_ip = 32'h0A00_0002; dest_port = 16'h1234;
        ch_port = {16'h1111, 16'h1F90, 16'h2222, 16'h3333};
        ch_en = 4'b0100;
        mdl_pkt[0] = 0; mdl_pkt[1] = 0; mdl_drop[0] = 0; mdl_drop[1] = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_m_valid", if1.m_valid, 0);
        chk("rst_m_data", if1.m_data, 0);
        chk("rst_m_keep", if1.m_keep, 0);
        chk("rst_m_chan_last_user", {if1.m_chan, if1.m_last, if1.m_user}, 0);
        chk("rst_counters", {pkt1, drop1, pkt0[15:0]}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 11-byte datagram on channel 2
        send_dgram(dest_ip, local_ip, dest_port, 16'h1F90, 11, 1'b0, 1'b1);
        wait_drain();

        // Lowest enabled matching channel wins
        ch_port = {16'h5000, 16'h1F90, 16'h5000, 16'h3333};
        ch_en = 4'b1010;
        send_dgram(dest_ip, local_ip, dest_port, 16'h5000, 4, 1'b0, 1'b0);
        ch_en = 4'b1000;
        send_dgram(dest_ip, local_ip, dest_port, 16'h5000, 4, 1'b0, 1'b0);
        wait_drain();

        // Source port mismatch: dropped with source check, accepted without
        ch_en = 4'b0100;
        send_dgram(dest_ip, local_ip, dest_port ^ 16'h0001, 16'h1F90, 20, 1'b0, 1'b0);
        wait_drain();
        use0 = 1'b1;
        send_dgram(dest_ip, local_ip, dest_port ^ 16'h0001, 16'h1F90, 20, 1'b0, 1'b0);
        wait_drain();
        use0 = 1'b0;

        // Output stall for 5 clocks after the first word of a 16-byte datagram
        m_ready = 1'b0;
        fork
            send_dgram(dest_ip, local_ip, dest_port, 16'h1F90, 16, 1'b0, 1'b1);
            begin
                for (int c = 0; c < 100 && !mv; c++) @(negedge clk);
                repeat (5) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        wait_drain();

        // Frame error flagged on the last byte of a 3-byte datagram
        send_dgram(dest_ip, local_ip, dest_port, 16'h1F90, 3, 1'b1, 1'b1);
        wait_drain();

        // Reset in the middle of an accepted datagram
        m_ready = 1'b0;
        do_hdr(dest_ip, local_ip, dest_port, 16'h1F90);
        for (int i = 0; i < 8; i++) do_byte(8'hA0 + 8'(i), 1'b0, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", if1.m_valid, 0);
        chk("midrst_m_data", if1.m_data, 0);
        chk("midrst_m_keep", if1.m_keep, 0);
        chk("midrst_m_chan_last_user", {if1.m_chan, if1.m_last, if1.m_user}, 0);
        chk("midrst_counters", {pkt1, drop1}, 0);
        chk("midrst_readies", {if1.s_hdr_ready, if1.s_payload_tready}, 2'b11);
        exp_q.delete();
        cur_bytes.delete();
        lat_due = 1'b0;
        mdl_pkt[0] = 0; mdl_pkt[1] = 0; mdl_drop[0] = 0; mdl_drop[1] = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        do_byte(8'hAA, 1'b0, 1'b0, 2);
        do_byte(8'hBB, 1'b0, 1'b0, 2);
        do_byte(8'hCC, 1'b1, 1'b1, 2);
        send_dgram(dest_ip, local_ip, dest_port, 16'h1F90, 5, 1'b0, 1'b0);
        wait_drain();

        // Randomized traffic with back-pressure and mid-datagram config changes
        rdy_rand = 1'b1;
        scramble = 1'b1;
        randomize_cfg();
        for (int t = 0; t < 80; t++) begin
            if ($urandom % 6 == 0) begin
                wait_drain();
                use0 = ~use0;
            end
            if ($urandom % 8 == 0) begin
                for (int s = 0; s < int'($urandom_range(1, 3)); s++)
                    do_byte(8'($urandom), 1'($urandom), 1'($urandom), 2);
            end
            r_sip = ($urandom % 5 == 0) ? $urandom : dest_ip;
            r_dip = ($urandom % 5 == 0) ? 32'hC0A8_0002 : local_ip;
            r_sp  = ($urandom % 5 == 0) ? 16'($urandom) : dest_port;
            r_dp  = 16'h0100 + 16'($urandom_range(0, 7));
            send_dgram(r_sip, r_dip, r_sp, r_dp, int'($urandom_range(1, 24)),
                       ($urandom % 3 == 0), 1'b0);
        end
        rdy_rand = 1'b0;
        #2 m_ready = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/udp_rx_chan_packer.md
Name: udp_rx_chan_packer

Overview:
Multi-channel successor to the single-port UDP receive filter/packer, running entirely in the core clock domain. It accepts UDP header plus byte payload from the UDP core and filters each datagram against up to CH_N enabled local ports, with an optional source IP/port check. Matching payload is packed little-endian into DATA_W words with byte-valid keep, tagged with the channel index and an error flag; non-matching datagrams are drained and counted. It sits between the UDP core and per-channel consumers or the downstream async FIFO.

Parameters:
DATA_W, 64, output word width; multiple of 8, range 8..512.
CH_N, 4, number of port-match channels, 1..16.
MATCH_SRC, 1, 1 = also require source IP == dest_ip and source port == dest_port; 0 = ignore source.
KEEP_W, DATA_W/8, derived; not overridable.
CH_W, max(1,clog2(CH_N)), derived channel-index width.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
s_hdr_valid  in  1  UDP header valid
s_hdr_ready  out  1  header accept
s_ip_source_ip  in  32  header source IP
s_ip_dest_ip  in  32  header destination IP
s_source_port  in  16  header source port
s_dest_port  in  16  header destination port
s_payload_tdata  in  8  payload byte
s_payload_tvalid  in  1  payload valid
s_payload_tready  out  1  payload ready
s_payload_tlast  in  1  last payload byte
s_payload_tuser  in  1  frame error, sampled with tlast
local_ip  in  32  required destination IP
dest_ip  in  32  required source IP (MATCH_SRC=1)
dest_port  in  16  required source port (MATCH_SRC=1)
ch_port  in  16*CH_N  channel k port at [16k+:16]
ch_en  in  CH_N  channel enable
m_data  out  DATA_W  packed word; first byte at [7:0]
m_keep  out  KEEP_W  byte-valid mask
m_chan  out  CH_W  channel index of word
m_valid  out  1  output word valid
m_last  out  1  last word of datagram
m_user  out  1  datagram error (valid on m_last)
m_ready  in  1  output accept
pkt_cnt  out  32  accepted datagrams, wrapping
drop_cnt  out  32  dropped datagrams, wrapping

Behaviour:
- Reset (rst_n=0, async assert, sync release by integrator): state IDLE; m_valid=0; m_last=0; m_user=0; m_data=0; m_keep=0; m_chan=0; counters=0; byte index=0.
- States: IDLE, ACCEPT, DROP.
- IDLE: s_hdr_ready=1; s_payload_tready=1 (stray bytes are discarded and not counted).
- On header handshake, compute match = dest_ip==local_ip && (MATCH_SRC==0 || source IP/port match) && some k with ch_en[k] && s_dest_port==ch_port[16k+:16].
- Lowest matching k wins and is latched as channel.
- match -> ACCEPT, pkt_cnt+1; else -> DROP, drop_cnt+1. Counter increments are registered on the handshake cycle.
- Config inputs are sampled only at header handshake; changes mid-datagram have no effect.
- s_hdr_ready=0 outside IDLE.
- DROP: s_payload_tready=1; tvalid&&tlast -> IDLE. Nothing is emitted.
- ACCEPT: s_payload_tready = !m_valid || m_ready. Each accepted byte goes to lane idx.
- Word completes when idx==KEEP_W-1 or tlast. In that same cycle, the output register loads buffer+byte: m_valid=1, m_keep=(1<<(idx+1))-1, m_last=tlast, m_user=tlast&tuser, m_chan=latched channel. idx then returns to 0.
- Unused lanes of a partial word are 0.
- tlast -> IDLE in the same cycle.
- Throughput: one byte/clk; the output register drains while collecting, so there is no bubble if m_ready stays high.
- Output holds m_data/m_keep/m_chan/m_last/m_user stable while m_valid && !m_ready. It clears m_valid on m_ready when no new word loads the same cycle.
- Latency: completing byte to m_valid = 1 clk.
- A header can be accepted in the cycle after tlast, even while the final word is still in the output register.
- DATA_W=8: every byte is its own word, keep=1.
- Counters wrap 0xFFFFFFFF -> 0.

Test Plan:
- Ch2 port 0x1F90 enabled, MATCH_SRC=1, 11-byte payload 0x00..0x0A, m_ready=1 -> two words: 0x0706050403020100 keep 0xFF last=0; then 0x00000000000A0908 keep 0x07 last=1, chan=2; pkt_cnt=1.
- Dest port matches ch1 and ch3 (both enabled) -> chan=1. Same port with ch1 disabled -> chan=3.
- Source port mismatch with MATCH_SRC=1 -> 20 bytes accepted at tready=1, no m_valid, drop_cnt=1. Same case with MATCH_SRC=0 -> accepted.
- 16-byte datagram, m_ready=0 for 5 clk after first word -> tready low while stalled, first word held stable, no byte lost; 2 words total.
- tuser=1 on tlast of a 3-byte datagram -> one word, keep=0x07, m_last=1, m_user=1.
- rst_n pulled low mid-ACCEPT -> outputs zero immediately; after release, trailing bytes are discarded in IDLE and the next matching header processes normally.
